// File: rtl/p_hardisc.sv
// Shared CSR address map and CSR operation encoding for the hardware
// performance monitor.
package p_hardisc;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT     = 12'h323;
  localparam logic [11:0] CSR_MHPMCOUNTER   = 12'hB03;
  localparam logic [11:0] CSR_MHPMCOUNTERH  = 12'hB83;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // New 32-bit register view produced by a CSR operation on the current view.
  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] cur,
                                            input logic [31:0] opnd);
    case (op)
      CSR_OP_WRITE: return opnd;
      CSR_OP_SET:   return cur | opnd;
      CSR_OP_CLEAR: return cur & ~opnd;
      default:      return cur;
    endcase
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One performance counter with its event selector, overflow-interrupt enable
// and sticky overflow flag.
module hpm_counter
  import p_hardisc::*;
#(
  parameter int CNT_W = 40,
  parameter int N_EVT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_EVT-1:0] event_i,
  input  logic             inhibit_i,
  input  logic             evt_we_i,
  input  logic             lo_we_i,
  input  logic             hi_we_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      evt_o,
  output logic [31:0]      cnt_lo_o,
  output logic [31:0]      cnt_hi_o,
  output logic             irq_o
);
  localparam int EVT_SW = $clog2(N_EVT + 1);

  logic [EVT_SW-1:0] sel_q, sel_d;
  logic              ofie_q, ofie_d;
  logic              of_q, of_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              evt_hit, inc, wrap;

  // Selector values 0 and above N_EVT match no event line.
  always_comb begin
    evt_hit = 1'b0;
    for (int e = 0; e < N_EVT; e++) begin
      if (sel_q == EVT_SW'(e + 1) && event_i[e]) evt_hit = 1'b1;
    end
  end

  assign inc  = evt_hit && !inhibit_i;
  assign wrap = inc && (&cnt_q);

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    ofie_d = ofie_q;
    of_d   = of_q;
    if (lo_we_i)      cnt_d = {cnt_q[CNT_W-1:32], wdata_i};
    else if (hi_we_i) cnt_d = CNT_W'({wdata_i, cnt_q[31:0]});
    else if (inc)     cnt_d = cnt_q + CNT_W'(1);
    if (evt_we_i) begin
      sel_d  = wdata_i[EVT_SW-1:0];
      ofie_d = wdata_i[30];
      of_d   = wdata_i[31];
    end
    // A software write to the counter discards the increment, so no wrap occurs;
    // otherwise the hardware overflow beats a same-cycle event-register write.
    if (wrap && !lo_we_i && !hi_we_i) of_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      ofie_q <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      ofie_q <= ofie_d;
      of_q   <= of_d;
    end
  end

  assign evt_o    = {of_q, ofie_q, 30'(sel_q)};
  assign cnt_lo_o = cnt_q[31:0];
  assign cnt_hi_o = 32'(cnt_q >> 32);
  assign irq_o    = of_q & ofie_q;

endmodule

// File: rtl/csr_hpm.sv
// Machine-mode hardware performance monitor CSR block: address decode, read
// mux, set/clear/write merge, count inhibit and the overflow interrupt.
module csr_hpm
  import p_hardisc::*;
#(
  parameter int N_CNT = 4,
  parameter int CNT_W = 40,
  parameter int N_EVT = 8
) (
  input  logic             s_clk_i,
  input  logic             s_resetn_i,
  input  logic             s_stall_i,
  input  logic             s_flush_i,
  input  logic [1:0]       s_csr_op_i,
  input  logic [11:0]      s_csr_add_i,
  input  logic [31:0]      s_csr_wval_i,
  input  logic [N_EVT-1:0] s_event_i,
  output logic [31:0]      s_csr_rval_o,
  output logic             s_csr_hit_o,
  output logic             s_ovf_int_o
);
  logic [N_CNT-1:0] inh_q, inh_d;
  logic             ovf_int_q;
  logic             inh_sel;
  logic [N_CNT-1:0] evt_sel, lo_sel, hi_sel, irq;
  logic [31:0]      evt_rd [N_CNT];
  logic [31:0]      lo_rd  [N_CNT];
  logic [31:0]      hi_rd  [N_CNT];
  logic [31:0]      rval, wdata;
  logic             we;

  always_comb begin
    inh_sel = (s_csr_add_i == CSR_MCOUNTINHIBIT);
    rval    = inh_sel ? (32'(inh_q) << 3) : 32'h0;
    for (int k = 0; k < N_CNT; k++) begin
      evt_sel[k] = (s_csr_add_i == CSR_MHPMEVENT    + 12'(k));
      lo_sel[k]  = (s_csr_add_i == CSR_MHPMCOUNTER  + 12'(k));
      hi_sel[k]  = (s_csr_add_i == CSR_MHPMCOUNTERH + 12'(k));
      if (evt_sel[k]) rval = rval | evt_rd[k];
      if (lo_sel[k])  rval = rval | lo_rd[k];
      if (hi_sel[k])  rval = rval | hi_rd[k];
    end
  end

  assign s_csr_hit_o  = inh_sel | (|evt_sel) | (|lo_sel) | (|hi_sel);
  assign s_csr_rval_o = rval;
  assign wdata        = csr_apply(csr_op_e'(s_csr_op_i), rval, s_csr_wval_i);
  assign we           = (s_csr_op_i != CSR_OP_NONE) && s_csr_hit_o && !s_stall_i && !s_flush_i;
  assign inh_d        = (we && inh_sel) ? wdata[3 +: N_CNT] : inh_q;

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    hpm_counter #(
      .CNT_W(CNT_W),
      .N_EVT(N_EVT)
    ) u_cnt (
      .clk_i    (s_clk_i),
      .rst_ni   (s_resetn_i),
      .event_i  (s_event_i),
      .inhibit_i(inh_q[g]),
      .evt_we_i (we && evt_sel[g]),
      .lo_we_i  (we && lo_sel[g]),
      .hi_we_i  (we && hi_sel[g]),
      .wdata_i  (wdata),
      .evt_o    (evt_rd[g]),
      .cnt_lo_o (lo_rd[g]),
      .cnt_hi_o (hi_rd[g]),
      .irq_o    (irq[g])
    );
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      inh_q     <= '0;
      ovf_int_q <= 1'b0;
    end else begin
      inh_q     <= inh_d;
      ovf_int_q <= |irq;
    end
  end

  assign s_ovf_int_o = ovf_int_q;

endmodule
